// File: rtl/fsk_tone_mod.sv
// Binary FSK modulator: one square-wave tone per serial bit, valid/ready input.
// Optional FSK_IDLE_MARK_EN: run the mark carrier on fsk_out while idle.
module fsk_tone_mod #(
  parameter int DIV_MARK   = 3,
  parameter int DIV_SPACE  = 6,
  parameter int BIT_CYCLES = 48,
  parameter int CNT_W      = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic bit_in,
  input  logic bit_valid,
  output logic bit_ready,
  output logic fsk_out,
  output logic busy,
  output logic bit_done
);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] MARK_LAST = CNT_W'(DIV_MARK - 1);
  localparam logic [CNT_W-1:0] SPC_LAST  = CNT_W'(DIV_SPACE - 1);

  typedef enum logic {
    IDLE,
    TX
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] tone_cnt;
  logic [CNT_W-1:0] tone_cnt_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] bit_cnt_nxt;
  logic [CNT_W-1:0] tone_last;
  logic             cur_bit;
  logic             cur_bit_nxt;
  logic             fsk_nxt;
  logic             end_of_bit;
  logic             accept;

  assign end_of_bit = (state == TX) && (bit_cnt == BIT_LAST);
  assign accept     = bit_valid && ((state == IDLE) || end_of_bit);
  assign tone_last  = cur_bit ? MARK_LAST : SPC_LAST;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = TX;
      TX:      if (end_of_bit && !bit_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Tone and bit counter next values
  always_comb begin
    tone_cnt_nxt = tone_cnt;
    bit_cnt_nxt  = bit_cnt;
    cur_bit_nxt  = cur_bit;
    fsk_nxt      = fsk_out;
    case (state)
      IDLE: begin
        if (accept) begin
          cur_bit_nxt  = bit_in;
          tone_cnt_nxt = '0;
          bit_cnt_nxt  = '0;
          fsk_nxt      = 1'b0;
        end else begin
`ifdef FSK_IDLE_MARK_EN
          if (tone_cnt == MARK_LAST) begin
            tone_cnt_nxt = '0;
            fsk_nxt      = ~fsk_out;
          end else begin
            tone_cnt_nxt = tone_cnt + 1'b1;
          end
`else
          tone_cnt_nxt = '0;
          fsk_nxt      = 1'b0;
`endif
        end
      end
      TX: begin
        if (tone_cnt == tone_last) begin
          tone_cnt_nxt = '0;
          fsk_nxt      = ~fsk_out;
        end else begin
          tone_cnt_nxt = tone_cnt + 1'b1;
        end
        if (bit_cnt != BIT_LAST) begin
          bit_cnt_nxt = bit_cnt + 1'b1;
        end else if (bit_valid) begin
          // End-of-bit reload overrides the tone step above
          cur_bit_nxt  = bit_in;
          tone_cnt_nxt = '0;
          bit_cnt_nxt  = '0;
          fsk_nxt      = 1'b0;
        end else begin
          tone_cnt_nxt = '0;
`ifdef FSK_IDLE_MARK_EN
          fsk_nxt      = fsk_out;
`else
          fsk_nxt      = 1'b0;
`endif
        end
      end
      default: begin
        tone_cnt_nxt = '0;
        bit_cnt_nxt  = '0;
        fsk_nxt      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tone_cnt <= '0;
      bit_cnt  <= '0;
      cur_bit  <= 1'b0;
      fsk_out  <= 1'b0;
    end else begin
      tone_cnt <= tone_cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
      cur_bit  <= cur_bit_nxt;
      fsk_out  <= fsk_nxt;
    end
  end

  // Output decode; all handshake outputs forced low while reset is asserted
  always_comb begin
    busy      = reset && (state == TX);
    bit_done  = reset && end_of_bit;
    bit_ready = reset && ((state == IDLE) || end_of_bit);
  end

endmodule

// File: doc/fsk_tone_mod.md
Name: fsk_tone_mod

Overview:
- Binary FSK modulator stage. Consumes a serial data bit stream through a valid/ready handshake.
- For each bit, emits a square-wave tone on fsk_out for a fixed number of clk cycles.
- Mark tone (bit 1) uses half-period DIV_MARK; space tone (bit 0) uses half-period DIV_SPACE.
- Tones come from internal enable-style counters in the same count-to-N-then-toggle style as the existing divider. No derived or gated clocks; everything runs on clk.

Parameters:
- DIV_MARK, 3: half-period of the mark tone in clk cycles; legal range 1 to 2^CNT_W-1.
- DIV_SPACE, 6: half-period of the space tone in clk cycles; legal range 1 to 2^CNT_W-1.
- BIT_CYCLES, 48: clk cycles per transmitted bit; legal range 2 to 2^CNT_W-1.
- CNT_W, 8: width of the tone counter and the bit counter.

Ports:
- clk, input, 1: single system clock; all logic on the rising edge.
- reset, input, 1: synchronous, active-low reset.
- bit_in, input, 1: data bit to transmit; sampled on handshake.
- bit_valid, input, 1: upstream has bit_in available.
- bit_ready, output, 1: block accepts bit_in this cycle.
- fsk_out, output, 1: modulated square-wave output.
- busy, output, 1: high while a bit is being transmitted (state TX).
- bit_done, output, 1: high during the last clk cycle of each bit.

Behaviour:
- Reset: clk is the single clock; reset is synchronous and active-low. When reset is sampled low at a clk edge:
  - state <= IDLE
  - fsk_out <= 0
  - tone_cnt <= 0, bit_cnt <= 0, cur_bit <= 0
  - Outputs while reset is low: bit_ready 0, busy 0, bit_done 0.
  - Reset overrides everything, including mid-bit; the partial bit is dropped with no bit_done.
- Handshake: a bit is accepted on an edge where bit_valid && bit_ready. bit_in is ignored at all other times.
- Output decoding (from registers only, no combinational path from inputs):
  - bit_ready = (state==IDLE) || (state==TX && bit_cnt==BIT_CYCLES-1)
  - bit_done = (state==TX && bit_cnt==BIT_CYCLES-1)
  - busy = (state==TX)
- IDLE state:
  - fsk_out held 0 and tone_cnt held 0, unless FSK_IDLE_MARK_EN is defined.
  - On accept: cur_bit <= bit_in, tone_cnt <= 0, bit_cnt <= 0, fsk_out <= 0, state <= TX.
- TX state, on every edge:
  - div = cur_bit ? DIV_MARK : DIV_SPACE.
  - If tone_cnt==div-1: tone_cnt <= 0 and fsk_out toggles. Otherwise tone_cnt increments.
  - If bit_cnt < BIT_CYCLES-1: bit_cnt increments.
  - If bit_cnt==BIT_CYCLES-1 (end of bit):
    - If bit_valid: accept the new bit with the same updates as in IDLE and stay in TX. This is back-to-back operation with no idle gap; fsk_out restarts at 0 each bit.
    - Otherwise: state <= IDLE, fsk_out <= 0, tone_cnt <= 0.
- Timing:
  - After the accepting edge, fsk_out is 0 for div cycles, then toggles every div cycles. Tone period = 2*div clk cycles.
  - Each bit occupies exactly BIT_CYCLES cycles in TX.
  - If BIT_CYCLES is not a multiple of 2*div, the last half-period is truncated.
- Boundaries:
  - div==1 toggles fsk_out every cycle.
  - bit_valid held high continuously gives an unbroken bit stream.
  - bit_valid high during TX, other than in the end-of-bit cycle, is not accepted and must be held by upstream.
  - Counters never wrap; the parameter ranges above guarantee this.

Optional Feature:
- Macro: FSK_IDLE_MARK_EN.
- Defined: in IDLE, tone_cnt and fsk_out run the mark tone (DIV_MARK), giving a continuous mark carrier on an idle line.
  - On accept, tone_cnt and fsk_out still reset to 0.
  - Return to IDLE does not force fsk_out to 0; the mark tone continues from tone_cnt=0.
  - Reset still drives fsk_out=0.
- Not defined: fsk_out is constant 0 in IDLE.

Test Plan:
- Reset values: hold reset=0 for 3 edges with bit_valid=1 -> fsk_out=0, bit_ready=0, busy=0, bit_done=0. After release, bit_ready=1.
- Single mark bit (DIV_MARK=3, BIT_CYCLES=12), bit_in=1 for one accept cycle -> fsk_out pattern 000111000111 over 12 cycles, bit_done high on cycle 12 only, then busy=0 and fsk_out=0.
- Single space bit (DIV_SPACE=6, BIT_CYCLES=12), bit_in=0 -> fsk_out 000000111111, then idle.
- Back-to-back bits 1,0,1 with bit_valid held high -> bit_ready high only in each bit's 12th cycle, no idle cycle, busy high for 36 cycles, fsk_out restarts at 0 at each bit.
- Reset mid-bit: pull reset low at cycle 5 of a mark bit -> next edge state IDLE, fsk_out=0, no bit_done; a following bit transmits normally.
- FSK_IDLE_MARK_EN defined, no traffic -> fsk_out toggles every 3 cycles in IDLE. After one space bit completes, the mark tone resumes with tone_cnt=0.
